reg_file_wb: RTL

Register-file commit stage of the 16-bit Harvard processor. It sits directly downstream of the write-back result mux. It accepts one 32-bit result per handshake, tagged with the 6-bit opcode and two destination addresses, and commits it to a 16×16 register array. MUL results take two cycles: the low half goes to Rdst1, the high half to Rdst2. The block also provides two combinational read ports with write-forwarding for the decode/operand-fetch stage.

---
 rtl/isa_pkg.sv | 33 +++
 rtl/reg_array.sv | 32 +++
 rtl/reg_file_wb.sv | 125 ++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit Harvard core: opcodes, data width and
// the register-write classification used by decode, write-back mux and commit.
package isa_pkg;

    localparam int DW = 16;

    typedef logic [5:0] op_t;

    localparam op_t OP_MOV0  = 6'b000000;
    localparam op_t OP_MOV1  = 6'b000001;
    localparam op_t OP_LOAD  = 6'b000010;
    localparam op_t OP_STORE = 6'b000011;
    localparam op_t OP_ADD   = 6'b000100;
    localparam op_t OP_SUB   = 6'b000101;
    localparam op_t OP_NEG   = 6'b000110;
    localparam op_t OP_MUL   = 6'b000111;
    localparam op_t OP_DIV   = 6'b001000;
    localparam op_t OP_OR    = 6'b001001;
    localparam op_t OP_XOR   = 6'b001010;
    localparam op_t OP_NAND  = 6'b001011;
    localparam op_t OP_NOR   = 6'b001100;
    localparam op_t OP_XNOR  = 6'b001101;
    localparam op_t OP_NOT   = 6'b001110;
    localparam op_t OP_LLSH  = 6'b001111;
    localparam op_t OP_LRSH  = 6'b010000;

    // Single-result ops that write Rdst1; MUL is handled separately because
    // it commits in two halves.
    function automatic logic is_reg_write(op_t op);
        return (op <= OP_LRSH) && (op != OP_STORE) && (op != OP_MUL);
    endfunction

endpackage

// File: rtl/reg_array.sv
// NREGS x DW architectural register storage: one synchronous write port,
// two asynchronous read ports, asynchronous active-low clear.
module reg_array #(
    parameter int NREGS = 16,
    parameter int DW    = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/reg_file_wb.sv
// Register-file commit stage: commits write-back results (two-cycle MUL) into
// the register array and serves two forwarded combinational read ports.
//
// state | meaning
// IDLE  | ready for a result; low-half / single writes happen on accept
// WR_HI | MUL high half pending; committed at the next edge, input stalled
module reg_file_wb #(
    parameter int NREGS = 16,
    parameter int DW    = isa_pkg::DW,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [5:0]    wb_op,
    input  logic [AW-1:0] wb_rdst1,
    input  logic [AW-1:0] wb_rdst2,
    input  logic [31:0]   wb_data,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    output logic          wb_done,
    output logic          busy
);

    import isa_pkg::*;

    typedef enum logic {
        IDLE  = 1'b0,
        WR_HI = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          accept;
    logic          is_mul;
    logic          lo_we;
    logic          hi_we;
    logic [DW-1:0] hi_data;
    logic [AW-1:0] hi_addr;
    logic          done_q;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] arr_a, arr_b;

    assign is_mul = (wb_op == OP_MUL);
    assign accept = wb_valid && wb_ready;
    assign lo_we  = accept && (is_reg_write(wb_op) || is_mul);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wb_ready  = 1'b0;
        busy      = 1'b0;
        hi_we     = 1'b0;
        case (state)
            IDLE: begin
                wb_ready = 1'b1;
                if (wb_valid && is_mul) state_nxt = WR_HI;
            end
            WR_HI: begin
                busy      = 1'b1;
                hi_we     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_data <= '0;
            hi_addr <= '0;
            done_q  <= 1'b0;
        end else begin
            if (accept && is_mul) begin
                hi_data <= wb_data[31:16];
                hi_addr <= wb_rdst2;
            end
            done_q <= (accept && !is_mul) || hi_we;
        end
    end

    assign wb_done = done_q;

    // Low and high writes never coincide: input is stalled while in WR_HI.
    assign we    = lo_we || hi_we;
    assign waddr = hi_we ? hi_addr : wb_rdst1;
    assign wdata = hi_we ? hi_data : wb_data[DW-1:0];

    reg_array #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) u_reg_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (arr_a),
        .rdata_b (arr_b)
    );

    always_comb begin
        rd_data_a = arr_a;
        if (hi_we && (hi_addr == rd_addr_a))        rd_data_a = hi_data;
        else if (lo_we && (wb_rdst1 == rd_addr_a))  rd_data_a = wb_data[DW-1:0];
    end

    always_comb begin
        rd_data_b = arr_b;
        if (hi_we && (hi_addr == rd_addr_b))        rd_data_b = hi_data;
        else if (lo_we && (wb_rdst1 == rd_addr_b))  rd_data_b = wb_data[DW-1:0];
    end

endmodule
